// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared definitions for the matrix-vector MAC controller:
//   state_t     - controller FSM states
//   ceil_div    - integer ceiling division, used to size the chunk count
//   clog2_min1  - address/index width that never collapses to zero bits
//   lane_byte   - extracts the signed byte of one lane from a packed word
// -----------------------------------------------------------------------------
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MAC    = 2'd1,
        REDUCE = 2'd2,
        OUT    = 2'd3
    } state_t;

    // Widest packed memory word lane_byte() can take apart (128 lanes).
    localparam int MAX_WORD_BITS = 1024;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // A single-entry range still needs a 1-bit signal to drive a port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Lane l of a packed word lives in bits [8l+7:8l]. Callers zero-extend
    // their word to MAX_WORD_BITS so one helper serves every lane count.
    function automatic logic signed [7:0] lane_byte(
        input logic [MAX_WORD_BITS-1:0] word,
        input int                       lane
    );
        return $signed(word[8*lane +: 8]);
    endfunction

endpackage

// File: rtl/mac_lane.sv
// -----------------------------------------------------------------------------
// mac_lane
// One lane of the MAC array: acc += w*a with the 16-bit signed product
// sign-extended to ACCW and the sum wrapping modulo 2^ACCW.
//   clk   in   clock
//   clr   in   clear the accumulator (wins over en)
//   en    in   a valid operand pair is present this cycle
//   mask  in   operand pair lies past the end of the row; contributes 0
//   w, a  in   signed 8-bit operands
//   acc   out  signed ACCW-bit running sum (ACCW must be at least 16)
// -----------------------------------------------------------------------------
module mac_lane #(
    parameter int ACCW = 32
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   mask,
    input  logic signed [7:0]      w,
    input  logic signed [7:0]      a,
    output logic signed [ACCW-1:0] acc
);

    logic signed [15:0]     prod;
    logic signed [ACCW-1:0] prod_ext;

    // Both operands are signed, so the product is computed signed at 16 bits
    // and the size cast sign-extends it to the accumulator width.
    assign prod     = w * a;
    assign prod_ext = ACCW'(prod);

    always_ff @(posedge clk) begin
        if (clr) begin
            acc <= '0;
        end else if (en && !mask) begin
            acc <= acc + prod_ext;
        end
    end

endmodule

// File: rtl/matvec_ctrl.sv
// -----------------------------------------------------------------------------
// matvec_ctrl
// Sequencing controller for a P-lane int8 MAC array computing y = W*x.
// For every row it streams CHUNKS packed words from the weight and
// activation RAMs, accumulates per lane, reduces the lanes serially and
// presents one result per row on a valid/ready stream.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   start                  begin a full ROWS pass (sampled only when idle)
//   busy                   high whenever the controller is not idle
//   done                   one-cycle pulse after the last row's handshake
//   w_rd_en / w_rd_addr    weight RAM read, address = row*CHUNKS + chunk
//   w_rd_data              weight word, 1-cycle latency, lane l = [8l+7:8l]
//   a_rd_en / a_rd_addr    activation RAM read, address = chunk
//   a_rd_data              activation word, same latency and packing
//   out_valid / out_ready  result handshake
//   out_data, out_row      signed dot product and its row index
// -----------------------------------------------------------------------------
module matvec_ctrl
    import matmul_pkg::*;
#(
    parameter  int ROWS   = 4,
    parameter  int COLS   = 70,
    parameter  int P      = 8,
    parameter  int ACCW   = 32,
    localparam int CHUNKS = ceil_div(COLS, P),
    localparam int WAW    = clog2_min1(ROWS * CHUNKS),
    localparam int AAW    = clog2_min1(CHUNKS),
    localparam int RW     = clog2_min1(ROWS)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   w_rd_en,
    output logic [WAW-1:0]         w_rd_addr,
    input  logic [8*P-1:0]         w_rd_data,
    output logic                   a_rd_en,
    output logic [AAW-1:0]         a_rd_addr,
    input  logic [8*P-1:0]         a_rd_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [ACCW-1:0] out_data,
    output logic [RW-1:0]          out_row
);

    localparam int IW = clog2_min1(P);
    // Number of live lanes in the final chunk of a row (1..P).
    localparam int TAIL = COLS - (CHUNKS - 1) * P;

    state_t                 state_reg;
    logic [RW-1:0]          row_reg;
    logic [AAW-1:0]         chunk_reg;      // chunk being requested
    logic [WAW-1:0]         w_addr_reg;
    logic                   rd_en_reg;
    logic                   rd_vld_reg;     // RAM data valid this cycle
    logic [AAW-1:0]         rd_chunk_reg;   // chunk the RAM data belongs to
    logic [IW-1:0]          idx_reg;
    logic signed [ACCW-1:0] out_data_reg;
    logic                   done_reg;

    logic signed [ACCW-1:0] lane_acc [P];
    logic                   lane_clr;
    logic                   last_chunk;
    logic                   last_row;

    assign last_chunk = (rd_chunk_reg == AAW'(CHUNKS - 1));
    assign last_row   = (row_reg == RW'(ROWS - 1));

    // Lane accumulators are cleared at the start of a pass, on the handshake
    // that advances to the next row, and while reset is held.
    always_comb begin
        lane_clr = 1'b0;
        if (!resetn) begin
            lane_clr = 1'b1;
        end else if (state_reg == IDLE && start) begin
            lane_clr = 1'b1;
        end else if (state_reg == OUT && out_ready && !last_row) begin
            lane_clr = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // MAC lanes
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_lane
            logic lane_mask;

            // Only lanes beyond the row's tail ever need masking, and only
            // while the last chunk of the row is being accumulated.
            if (gi >= TAIL) begin : g_tail
                assign lane_mask = last_chunk;
            end else begin : g_full
                assign lane_mask = 1'b0;
            end

            mac_lane #(
                .ACCW (ACCW)
            ) u_lane (
                .clk  (clk),
                .clr  (lane_clr),
                .en   (rd_vld_reg),
                .mask (lane_mask),
                .w    (lane_byte(MAX_WORD_BITS'(w_rd_data), gi)),
                .a    (lane_byte(MAX_WORD_BITS'(a_rd_data), gi)),
                .acc  (lane_acc[gi])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Controller FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            row_reg      <= '0;
            chunk_reg    <= '0;
            w_addr_reg   <= '0;
            rd_en_reg    <= 1'b0;
            rd_vld_reg   <= 1'b0;
            rd_chunk_reg <= '0;
            idx_reg      <= '0;
            out_data_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg     <= 1'b0;
            // Read-valid pipeline mirrors the fixed 1-cycle RAM latency.
            rd_vld_reg   <= rd_en_reg;
            rd_chunk_reg <= chunk_reg;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg    <= MAC;
                        row_reg      <= '0;
                        chunk_reg    <= '0;
                        w_addr_reg   <= '0;
                        rd_en_reg    <= 1'b1;
                        out_data_reg <= '0;
                    end
                end

                MAC: begin
                    // Request side: walk chunk 0..CHUNKS-1 then stop. The
                    // address stays on the last chunk until the next row.
                    if (rd_en_reg) begin
                        if (chunk_reg == AAW'(CHUNKS - 1)) begin
                            rd_en_reg <= 1'b0;
                        end else begin
                            chunk_reg  <= chunk_reg + AAW'(1);
                            w_addr_reg <= w_addr_reg + WAW'(1);
                        end
                    end
                    // Accumulate side: the lanes absorb the last chunk on
                    // this edge, so reduction may start next cycle.
                    if (rd_vld_reg && last_chunk) begin
                        state_reg    <= REDUCE;
                        idx_reg      <= '0;
                        out_data_reg <= '0;
                    end
                end

                REDUCE: begin
                    out_data_reg <= out_data_reg + lane_acc[idx_reg];
                    if (idx_reg == IW'(P - 1)) begin
                        state_reg <= OUT;
                    end else begin
                        idx_reg <= idx_reg + IW'(1);
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        if (last_row) begin
                            state_reg <= IDLE;
                            done_reg  <= 1'b1;
                        end else begin
                            // Next row's first read issues right after the
                            // handshake; its weights follow contiguously.
                            state_reg  <= MAC;
                            row_reg    <= row_reg + RW'(1);
                            chunk_reg  <= '0;
                            w_addr_reg <= w_addr_reg + WAW'(1);
                            rd_en_reg  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign w_rd_en   = rd_en_reg;
    assign a_rd_en   = rd_en_reg;
    assign w_rd_addr = w_addr_reg;
    assign a_rd_addr = chunk_reg;
    assign out_valid = (state_reg == OUT);
    assign out_data  = out_data_reg;
    assign out_row   = row_reg;

endmodule

// File: doc/matvec_ctrl.md
# matvec_ctrl

Sequencing controller for a P-lane int8 MAC array that computes an output vector y = W·x. W has ROWS×COLS entries; x has COLS entries. For each output row the block reads packed weight and activation words, accumulates the products across P parallel lanes, reduces the lanes serially and presents one result per row on a valid/ready stream. It sits between the on-chip weight/activation RAMs and the requantization stage of the inference pipeline.

## Interface
- ROWS, default 4: number of output rows (≥1).
- COLS, default 70: dot-product length (≥1).
- P, default 8: MAC lanes; also the number of bytes per memory word.
- ACCW, default 32: lane and result accumulator width.
- CHUNKS, derived: ceil(COLS/P), the number of words per row.
- WAW, AAW, derived: weight address width $clog2(ROWS·CHUNKS); activation address width $clog2(CHUNKS).
- Reset is resetn, synchronous, active-low; the clock is clk.
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  begin a full ROWS pass; sampled only in IDLE.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse after the last row's handshake.
- w_rd_en  out  1  weight RAM read enable.
- w_rd_addr  out  WAW  weight word address, equal to row·CHUNKS + chunk.
- w_rd_data  in  8·P  weight word; lane l occupies bits [8l+7:8l], signed.
- a_rd_en  out  1  activation RAM read enable.
- a_rd_addr  out  AAW  activation word address, equal to chunk.
- a_rd_data  in  8·P  activation word, same packing, signed.
- out_valid  out  1  a result is available.
- out_ready  in  1  the consumer accepts the result.
- out_data  out  ACCW  signed dot product.
- out_row  out  $clog2(ROWS)  row index of out_data.

## Operation
- States: IDLE, MAC, REDUCE, OUT.
- IDLE: start=1 clears row, chunk, lane accumulators and out_data, then moves to MAC.
- MAC: runs for CHUNKS+1 cycles.
  - The first CHUNKS cycles assert w_rd_en/a_rd_en with chunk = 0..CHUNKS-1.
  - Both RAMs have a fixed 1-cycle read latency. Each lane does acc[l] += w[l]·a[l] in the cycle after the read.
  - Lanes where chunk·P + l ≥ COLS contribute 0 (tail mask). For COLS=70, P=8, lanes 6 and 7 are masked in chunk 8.
  - After the last accumulate, go to REDUCE with idx=0 and out_data=0.
- REDUCE: each cycle does out_data += acc[idx] and idx++. After P cycles go to OUT.
- OUT: out_valid=1 with out_data and out_row held stable until out_ready=1.
  - On handshake, if row < ROWS-1: increment row, clear the lane accumulators, go to MAC.
  - Otherwise pulse done and go to IDLE.
- Arithmetic: 8×8 signed products sign-extended to ACCW. All sums wrap modulo 2^ACCW; no saturation.
- start is ignored while busy.
- resetn=0 mid-operation returns to IDLE next edge and abandons the pass; in-flight read data is discarded.

## Timing
- Reset values: busy=0, done=0, w_rd_en=0, a_rd_en=0, both addresses 0, out_valid=0, out_data=0, out_row=0.
- out_valid rises CHUNKS+P+1 cycles after the edge that samples start. With defaults this is 18.
- Per-row cost with out_ready held high is CHUNKS+P+2 cycles. The handshake cycle and the next row's first MAC cycle are consecutive.
- done is asserted the cycle after the final handshake, and busy falls in that same cycle.
- out_ready may be held high early; the transfer occurs only when out_valid=1.

## Structure
- Package matmul_pkg holds:
  - the state enum {IDLE, MAC, REDUCE, OUT};
  - a ceil_div function used to compute CHUNKS;
  - the lane byte-extract helper.
- Sub-module mac_lane, instantiated P times, with ports clk, clr, en, mask, signed 8-bit w, signed 8-bit a, and ACCW-bit acc.
- The controller holds the FSM, row/chunk/idx counters, read-valid pipeline bit, reduction register and output handshake.

## Test plan
- Sum of squares: defaults, ROWS=1, w[i]=a[i]=i+1 for i=0..69 → out_data=116795, out_row=0, out_valid 18 cycles after start, then done 1 cycle after the handshake.
- Signed extremes: COLS=8, P=8, all weights and activations −128 → out_data=131072. With w=−128 and a=127 → −130048.
- Wrap: ACCW=16, COLS=8, all operands 127 → 8·16129=129032 mod 65536 = 63496, presented as out_data=0xF808.
- Backpressure: ROWS=3, out_ready low for 5 cycles on row 1 → out_data and out_row stable throughout, no extra RAM reads, rows delivered in order 0, 1, 2.
- Start while busy and reset mid-pass: start re-pulsed during MAC is ignored. resetn=0 during REDUCE gives all outputs at reset values next cycle, and a fresh start then produces correct row-0 results.
